// File: rtl/metric_packer.sv
// metric_packer: upstream feeder for the 4-lane sorter.
//
// Collects one frame of candidate metrics over a valid/ready handshake, then
// issues a one-cycle start pulse, waits START_GAP idle cycles, and streams the
// frame as consecutive 4-lane beats on d1..d4. It then holds off new input
// until the sorter reports done. A frame is 4 metrics for QPSK (M=00) and
// 16 metrics otherwise. A reserved m_in value (1x) is sent as QAM16 and sets
// the sticky m_err flag.
//
// Optional feature macro: METRIC_PACKER_SAT_EN
//   defined   : metrics above 2^WIDTH-1 are clamped to 2^WIDTH-1 before storage
//   undefined : only the low WIDTH bits of in_data are stored
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous reset, active low
//   m_in         modulation select (00 QPSK, 01 QAM16, 1x reserved)
//   in_valid     in_data holds a valid metric
//   in_data      candidate metric, IN_WIDTH bits
//   in_ready     packer accepts in_data this cycle
//   sorter_done  done from the sorter
//   start        one-cycle start pulse to the sorter
//   M            modulation to the sorter, stable for the whole frame
//   d1..d4       lane data to the sorter, WIDTH bits each
//   busy         high from the first accepted metric until sorter_done
//   m_err        sticky reserved-modulation flag, cleared only by reset

// One sorter lane: holds the four metrics that land on this lane (metric
// index k with k%4 == lane) and registers the lane output for each beat.
module metric_packer_lane #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [1:0]       wslot,
  input  logic [WIDTH-1:0] wdata,
  input  logic             drive,
  input  logic [1:0]       rslot,
  output logic [WIDTH-1:0] d
);
  logic [3:0][WIDTH-1:0] mem;

  // Frame storage needs no reset: it is always fully rewritten before it is read.
  always_ff @(posedge clk) begin
    if (we) mem[wslot] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst)       d <= '0;
    else if (drive) d <= mem[rslot];
    else            d <= '0;
  end
endmodule

module metric_packer #(
  parameter int WIDTH     = 8,
  parameter int IN_WIDTH  = 12,
  parameter int START_GAP = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          m_in,
  input  logic                in_valid,
  input  logic [IN_WIDTH-1:0] in_data,
  output logic                in_ready,
  input  logic                sorter_done,
  output logic                start,
  output logic [1:0]          M,
  output logic [WIDTH-1:0]    d1,
  output logic [WIDTH-1:0]    d2,
  output logic [WIDTH-1:0]    d3,
  output logic [WIDTH-1:0]    d4,
  output logic                busy,
  output logic                m_err
);
  localparam int NUM_LANES = 4;
  localparam int GW        = (START_GAP > 1) ? $clog2(START_GAP) : 1;
  localparam logic [WIDTH-1:0] MAX_V = '1;

  typedef enum logic [2:0] {
    S_COLLECT,
    S_START,
    S_GAP,
    S_SEND,
    S_WAIT_DONE
  } state_t;

  state_t          state, state_nxt;
  logic [3:0]      wr_cnt, wr_cnt_nxt;
  logic [1:0]      beat, beat_nxt;
  logic [GW-1:0]   gap_cnt, gap_nxt;
  logic            accept;
  logic            last_metric;
  logic [1:0]      last_beat;
  logic [WIDTH-1:0] store_val;
  logic [NUM_LANES-1:0][WIDTH-1:0] lane_d;

  // Metric width reduction before storage.
`ifdef METRIC_PACKER_SAT_EN
  always_comb begin
    store_val = in_data[WIDTH-1:0];
    if (in_data > IN_WIDTH'(MAX_V)) store_val = MAX_V;
  end
`else
  logic unused_hi;
  assign unused_hi = ^in_data;
  always_comb begin
    store_val = in_data[WIDTH-1:0];
  end
`endif

  assign accept = in_valid & in_ready;

  // M is latched on the first accept; the last-metric test can never fire at
  // count 0, so using the registered M here is always the frame's M.
  assign last_metric = (M == 2'b00) ? (wr_cnt == 4'd3) : (wr_cnt == 4'd15);
  assign last_beat   = (M == 2'b00) ? 2'd0 : 2'd3;

  always_comb begin
    state_nxt  = state;
    wr_cnt_nxt = wr_cnt;
    beat_nxt   = beat;
    gap_nxt    = gap_cnt;
    case (state)
      S_COLLECT: begin
        if (accept) begin
          wr_cnt_nxt = wr_cnt + 4'd1;
          if (last_metric) state_nxt = S_START;
        end
      end
      S_START: begin
        beat_nxt  = '0;
        gap_nxt   = '0;
        state_nxt = (START_GAP == 0) ? S_SEND : S_GAP;
      end
      S_GAP: begin
        if (gap_cnt == GW'(START_GAP - 1)) state_nxt = S_SEND;
        else                               gap_nxt   = gap_cnt + 1'b1;
      end
      S_SEND: begin
        if (beat == last_beat) state_nxt = S_WAIT_DONE;
        else                   beat_nxt  = beat + 2'd1;
      end
      S_WAIT_DONE: begin
        if (sorter_done) begin
          state_nxt  = S_COLLECT;
          wr_cnt_nxt = '0;
        end
      end
      default: state_nxt = S_COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_COLLECT;
      wr_cnt   <= '0;
      beat     <= '0;
      gap_cnt  <= '0;
      in_ready <= 1'b1;
      start    <= 1'b0;
      M        <= 2'b00;
      busy     <= 1'b0;
      m_err    <= 1'b0;
    end else begin
      state    <= state_nxt;
      wr_cnt   <= wr_cnt_nxt;
      beat     <= beat_nxt;
      gap_cnt  <= gap_nxt;
      // Outputs are decoded from the next state so they line up with it.
      in_ready <= (state_nxt == S_COLLECT);
      start    <= (state_nxt == S_START);
      if (accept && wr_cnt == 4'd0) begin
        M     <= m_in[1] ? 2'b01 : m_in;
        busy  <= 1'b1;
        m_err <= m_err | m_in[1];
      end
      if (state == S_WAIT_DONE && sorter_done) busy <= 1'b0;
    end
  end

  // Metric k lands in lane k%4, slot k/4, so beat b reads slot b on every lane.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    metric_packer_lane #(.WIDTH(WIDTH)) u_lane (
      .clk   (clk),
      .rst   (rst),
      .we    (accept && (wr_cnt[1:0] == 2'(i))),
      .wslot (wr_cnt[3:2]),
      .wdata (store_val),
      .drive (state_nxt == S_SEND),
      .rslot (beat_nxt),
      .d     (lane_d[i])
    );
  end

  assign d1 = lane_d[0];
  assign d2 = lane_d[1];
  assign d3 = lane_d[2];
  assign d4 = lane_d[3];
endmodule

// File: tb/tb_metric_packer.sv
// Self-checking bench for metric_packer: directed frames from the test plan
// plus randomized frames, checked against a frame-level model of the packer.
module tb_metric_packer;
  localparam int WIDTH     = 8;
  localparam int IN_WIDTH  = 12;
  localparam int START_GAP = 1;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [1:0]          m_in = 2'b00;
  logic                in_valid = 1'b0;
  logic [IN_WIDTH-1:0] in_data = '0;
  logic                in_ready;
  logic                sorter_done = 1'b0;
  logic                start;
  logic [1:0]          M;
  logic [WIDTH-1:0]    d1, d2, d3, d4;
  logic                busy;
  logic                m_err;

  int n_chk = 0;
  int n_err = 0;
  int exp_err = 0;

  always #5 clk = ~clk;

  metric_packer #(.WIDTH(WIDTH), .IN_WIDTH(IN_WIDTH), .START_GAP(START_GAP)) dut (
    .clk(clk), .rst(rst), .m_in(m_in), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .sorter_done(sorter_done), .start(start), .M(M),
    .d1(d1), .d2(d2), .d3(d3), .d4(d4), .busy(busy), .m_err(m_err)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_d(input string tag, input int e1, input int e2, input int e3, input int e4);
    chk({tag, "_d1"}, int'(d1), e1);
    chk({tag, "_d2"}, int'(d2), e2);
    chk({tag, "_d3"}, int'(d3), e3);
    chk({tag, "_d4"}, int'(d4), e4);
  endtask

  // Value the sorter should see for a given input metric.
  function automatic int mstore(input int v);
    int maxv;
    maxv = (1 << WIDTH) - 1;
`ifdef METRIC_PACKER_SAT_EN
    return (v > maxv) ? maxv : v;
`else
    return v & maxv;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one frame and checks the whole start/gap/beat/done sequence.
  // gap_mode: 0 back-to-back, 1 idle every other cycle, 2 random idles.
  // abort_beat >= 0 resets the packer while that beat is on the outputs.
  task automatic run_frame(input logic [1:0] m0, input int vals[16], input int gap_mode,
                           input int done_dly, input bit hold77, input int abort_beat);
    int n;
    int em;
    n  = (m0 == 2'b00) ? 4 : 16;
    em = m0[1] ? 1 : int'(m0);
    for (int i = 0; i < n; i++) begin
      if (i > 0 && (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 1) == 1))) begin
        in_valid    = 1'b0;
        m_in        = 2'($urandom_range(0, 3));
        sorter_done = 1'($urandom_range(0, 1));
        tick();
        chk("rdy_idle", int'(in_ready), 1);
        chk("busy_idle", int'(busy), 1);
      end
      in_valid    = 1'b1;
      in_data     = IN_WIDTH'(vals[i]);
      m_in        = (i == 0) ? m0 : 2'($urandom_range(0, 3));
      sorter_done = 1'($urandom_range(0, 1));
      tick();
      if (i == 0) begin
        if (m0[1]) exp_err = 1;
        chk("busy_first", int'(busy), 1);
        chk("m_latch", int'(M), em);
        chk("m_err", int'(m_err), exp_err);
      end
      if (i < n - 1) begin
        chk("rdy_collect", int'(in_ready), 1);
        chk("no_start", int'(start), 0);
      end else begin
        chk("start_pulse", int'(start), 1);
        chk("rdy_drop", int'(in_ready), 0);
      end
    end
    in_valid = hold77;
    in_data  = hold77 ? IN_WIDTH'(77) : '0;
    m_in     = 2'($urandom_range(0, 3));
    for (int g = 0; g < START_GAP; g++) begin
      sorter_done = 1'($urandom_range(0, 1));
      tick();
      chk("gap_start", int'(start), 0);
      chk_d("gap", 0, 0, 0, 0);
    end
    for (int b = 0; b < n / 4; b++) begin
      sorter_done = 1'($urandom_range(0, 1));
      tick();
      chk("beat_start", int'(start), 0);
      chk("beat_m", int'(M), em);
      chk("beat_busy", int'(busy), 1);
      chk_d("beat", mstore(vals[4*b]), mstore(vals[4*b+1]), mstore(vals[4*b+2]), mstore(vals[4*b+3]));
      if (b == abort_beat) begin
        rst         = 1'b0;
        sorter_done = 1'b0;
        in_valid    = 1'b0;
        tick();
        exp_err = 0;
        chk_d("rst", 0, 0, 0, 0);
        chk("rst_start", int'(start), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_rdy", int'(in_ready), 1);
        chk("rst_merr", int'(m_err), 0);
        rst = 1'b1;
        return;
      end
    end
    sorter_done = 1'($urandom_range(0, 1));
    tick();
    chk_d("post", 0, 0, 0, 0);
    chk("post_rdy", int'(in_ready), 0);
    chk("post_busy", int'(busy), 1);
    sorter_done = 1'b0;
    for (int w = 0; w < done_dly; w++) begin
      tick();
      chk("wait_rdy", int'(in_ready), 0);
      chk("wait_busy", int'(busy), 1);
    end
    sorter_done = 1'b1;
    tick();
    sorter_done = 1'b0;
    chk("done_rdy", int'(in_ready), 1);
    chk("done_busy", int'(busy), 0);
    if (!hold77) in_valid = 1'b0;
  endtask

  initial begin
    int v[16];
    logic [1:0] mr;
    tick();
    tick();
    chk("rst_rdy0", int'(in_ready), 1);
    chk("rst_start0", int'(start), 0);
    chk("rst_m0", int'(M), 0);
    chk("rst_busy0", int'(busy), 0);
    chk("rst_merr0", int'(m_err), 0);
    chk_d("rst0", 0, 0, 0, 0);
    rst = 1'b1;

    // QAM16 back-to-back frame
    v = '{10, 20, 1, 0, 9, 10, 11, 12, 5, 6, 7, 8, 47, 48, 49, 50};
    run_frame(2'b01, v, 0, 2, 1'b0, -1);

    // QPSK frame, then backpressure with 77 held while done is delayed
    v = '{3, 0, 5, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    run_frame(2'b00, v, 0, 6, 1'b1, -1);
    v = '{77, 1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    run_frame(2'b00, v, 0, 1, 1'b0, -1);

    // Gapped QAM16 with m_in changing mid-frame
    for (int i = 0; i < 16; i++) v[i] = $urandom_range(0, 255);
    run_frame(2'b01, v, 1, 3, 1'b0, -1);

    // Reset during the second beat, then a fresh QPSK frame
    for (int i = 0; i < 16; i++) v[i] = $urandom_range(1, 255);
    run_frame(2'b01, v, 0, 0, 1'b0, 1);
    v = '{4, 3, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    run_frame(2'b00, v, 0, 0, 1'b0, -1);

    // Out-of-range metrics
    v = '{300, 4095, 255, 256, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    run_frame(2'b00, v, 0, 1, 1'b0, -1);

    // Reserved modulation
    for (int i = 0; i < 16; i++) v[i] = $urandom_range(0, 4095);
    run_frame(2'b10, v, 0, 1, 1'b0, -1);

    // Randomized frames
    for (int f = 0; f < 8; f++) begin
      mr = 2'($urandom_range(0, 3));
      for (int i = 0; i < 16; i++) v[i] = $urandom_range(0, 4095);
      run_frame(mr, v, 2, $urandom_range(0, 5), 1'b0, -1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/metric_packer.md
Name: metric_packer

Overview:
- Upstream feeder for the 4-lane sorter.
- Accepts candidate distance metrics serially, one per cycle, over a valid/ready handshake, and buffers one frame.
- Frame size is 4 metrics for QPSK (M=00) and 16 for QAM16 (M=01).
- Then issues the sorter's start pulse, drives the frame as consecutive 4-lane beats on d1..d4 with a stable M, and waits for the sorter's done before accepting the next frame.

Parameters:
- WIDTH, 8: sorter lane width in bits.
- IN_WIDTH, 12: input metric width in bits; must be >= WIDTH.
- START_GAP, 1: idle cycles between the start pulse and the first data beat.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-low.
- m_in  input  2  modulation select: 00 = QPSK, 01 = QAM16, 1x = reserved.
- in_valid  input  1  in_data holds a valid metric.
- in_data  input  IN_WIDTH  candidate metric.
- in_ready  output  1  packer accepts in_data this cycle.
- sorter_done  input  1  done from sorter.
- start  output  1  one-cycle start pulse to sorter.
- M  output  2  modulation to sorter; held stable for the whole frame.
- d1, d2, d3, d4  output  WIDTH each  lane data to sorter.
- busy  output  1  high from the first accepted metric until sorter_done is seen.
- m_err  output  1  sticky flag: a reserved m_in value was captured; cleared only by reset.

Behaviour:
- Reset (rst=0 at a clock edge) values: state=COLLECT, in_ready=1, start=0, M=00, d1..d4=0, busy=0, m_err=0, write count=0.
- Reset mid-frame aborts the frame and discards all buffered data.
- Storage: 16 x WIDTH register buffer plus a 4-bit write count. Frame length N = 4 if captured M=00, otherwise 16.
- Reserved M values (1x): drive M=01 and set m_err.

States:
- COLLECT
  - in_ready=1. A metric is accepted when in_valid & in_ready.
  - On the first accepted metric (count=0), latch m_in into M and set busy.
  - m_in is ignored for the rest of the frame.
  - Metric k is stored at buf[k].
  - When the N-th metric is accepted, go to START. in_ready drops to 0 in the following cycle.
- START
  - start=1 for exactly one cycle.
  - Then go to GAP, or straight to SEND if START_GAP=0.
- GAP
  - Hold for START_GAP cycles with d1..d4=0.
- SEND
  - Drive N/4 consecutive beats, one per cycle, with no bubbles.
  - Beat b: d1=buf[4b], d2=buf[4b+1], d3=buf[4b+2], d4=buf[4b+3].
  - After the last beat, d1..d4 return to 0 and the state goes to WAIT_DONE.
- WAIT_DONE
  - in_ready=0, outputs idle.
  - On sorter_done=1: clear busy, reset count to 0, go to COLLECT.
  - A done pulse seen in any other state is ignored.
- Registering and latency:
  - All outputs are registered.
  - QPSK: start is asserted the cycle after the 4th accept.
  - QAM16: the first beat appears START_GAP+1 cycles after start.
- M may not change while busy.
- in_valid while in_ready=0 is not accepted; the upstream holds its data, and the metric is not lost.

Optional Feature:
- Macro: METRIC_PACKER_SAT_EN.
- Defined: an in_data value greater than 2^WIDTH-1 is clamped to 2^WIDTH-1 before storage, so large distances still sort last.
- Undefined: the low WIDTH bits of in_data are stored (truncation); the upper bits are ignored.

Test Plan:
- QAM16 frame:
  - Stimulus: m_in=01; feed metrics 10,20,1,0, 9,10,11,12, 5,6,7,8, 47,48,49,50 back-to-back.
  - Required: start pulses once; after 1 gap cycle, beats (d1..d4) = (10,20,1,0), (9,10,11,12), (5,6,7,8), (47,48,49,50) on consecutive cycles. M=01 throughout, then d=0.
- QPSK frame:
  - Stimulus: m_in=00; feed 3,0,5,3.
  - Required: a single beat (3,0,5,3), M=00, start high for exactly one cycle.
- Backpressure:
  - Stimulus: after a frame is sent, hold in_valid=1 with value 77 and delay sorter_done by 6 cycles.
  - Required: in_ready=0 until the cycle after done; 77 is then captured as buf[0] of the next frame.
- Gapped input and m_in change:
  - Stimulus: QAM16 with in_valid toggling every other cycle; m_in switched to 00 mid-frame.
  - Required: still 16 metrics and 4 beats; M stays 01.
- Reset mid-SEND:
  - Stimulus: rst=0 during beat 2.
  - Required: next edge gives d=0, start=0, busy=0, in_ready=1. A fresh QPSK frame then works.
- Saturation:
  - Stimulus: in_data=300 with WIDTH=8.
  - Required: d=255 with METRIC_PACKER_SAT_EN defined, d=44 without. Also, m_in=10 sets m_err=1 and drives M=01.
